// File: rtl/dnn_fixed_pkg.sv
// Shared fixed-point definitions for the DNN training datapath.
// Default Q-format, saturation limits and divider FSM state encoding.
package dnn_fixed_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned FRAC  = 24;

  localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] Q_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } div_state_e;

endpackage

// File: rtl/div_fixed_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor when it fits.
module div_fixed_step #(
  parameter int unsigned Width = 33
) (
  input  logic [Width-1:0] rem_i,
  input  logic             bit_i,
  input  logic [Width-1:0] div_i,
  output logic [Width-1:0] rem_o,
  output logic             q_o
);

  logic [Width:0] shifted;

  always_comb begin
    shifted = {rem_i, bit_i};
    if (shifted >= {1'b0, div_i}) begin
      q_o   = 1'b1;
      // True difference is below div_i, so modulo-2^Width subtraction is exact.
      rem_o = shifted[Width-1:0] - div_i;
    end else begin
      q_o   = 1'b0;
      rem_o = shifted[Width-1:0];
    end
  end

endmodule

// File: rtl/div_fixed.sv
// Iterative signed fixed-point divider, one quotient bit per clock (restoring).
// Truncates toward zero, saturates to the Q-format range and flags divide-by-zero.
module div_fixed #(
  parameter int unsigned WIDTH = dnn_fixed_pkg::WIDTH,
  parameter int unsigned FRAC  = dnn_fixed_pkg::FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_q,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_dz,
  output logic             o_sat
);

  import dnn_fixed_pkg::*;

  localparam int unsigned N    = WIDTH + FRAC;
  localparam int unsigned MagW = WIDTH + 1;
  localparam int unsigned CntW = $clog2(N);

  localparam logic [N-1:0]     NegLim = {{FRAC{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [N-1:0]     PosLim = NegLim - {{(N-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] QMax   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] QMin   = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e state_q, state_d;

  logic            sign_q, sign_d;
  logic            a_neg_q, a_neg_d;
  logic            b_zero_q, b_zero_d;
  logic [MagW-1:0] b_mag_q, b_mag_d;
  logic [MagW-1:0] rem_q, rem_d;
  logic [N:0]      dvd_q, dvd_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] res_q, res_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             dz_q, dz_d;
  logic             sat_q, sat_d;

  logic [MagW-1:0] a_ext, b_ext, a_mag, b_mag;
  logic [MagW-1:0] step_rem;
  logic            step_q;

  // Sign-extend by one bit so that |-2^(WIDTH-1)| is representable.
  always_comb begin
    a_ext = {i_a[WIDTH-1], i_a};
    b_ext = {i_b[WIDTH-1], i_b};
    a_mag = a_ext[WIDTH] ? (~a_ext + 1'b1) : a_ext;
    b_mag = b_ext[WIDTH] ? (~b_ext + 1'b1) : b_ext;
  end

  // The dividend MSB is always zero (|a| <= 2^(WIDTH-1)), so N steps consume bits N-1..0.
  div_fixed_step #(
    .Width (MagW)
  ) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[N-1]),
    .div_i (b_mag_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    a_neg_d  = a_neg_q;
    b_zero_d = b_zero_q;
    b_mag_d  = b_mag_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    dz_d     = dz_q;
    sat_d    = sat_q;

    case (state_q)
      StIdle: begin
        if (i_start) begin
          sign_d   = a_ext[WIDTH] ^ b_ext[WIDTH];
          a_neg_d  = a_ext[WIDTH];
          b_zero_d = (i_b == '0);
          b_mag_d  = b_mag;
          dvd_d    = {a_mag, {FRAC{1'b0}}};
          rem_d    = '0;
          quo_d    = '0;
          cnt_d    = CntW'(N - 1);
          busy_d   = 1'b1;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        rem_d = step_rem;
        quo_d = {quo_q[N-2:0], step_q};
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        valid_d = 1'b1;
        if (b_zero_q) begin
          res_d = a_neg_q ? QMin : QMax;
          dz_d  = 1'b1;
          sat_d = 1'b0;
        end else if (!sign_q) begin
          dz_d  = 1'b0;
          sat_d = (quo_q > PosLim);
          res_d = sat_d ? QMax : quo_q[WIDTH-1:0];
        end else begin
          dz_d  = 1'b0;
          sat_d = (quo_q > NegLim);
          res_d = sat_d ? QMin : (~quo_q[WIDTH-1:0] + 1'b1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      a_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      b_mag_q  <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      dz_q     <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      a_neg_q  <= a_neg_d;
      b_zero_q <= b_zero_d;
      b_mag_q  <= b_mag_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      dz_q     <= dz_d;
      sat_q    <= sat_d;
    end
  end

  assign o_q     = res_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_dz    = dz_q;
  assign o_sat   = sat_q;

endmodule

// File: tb/tb_div_fixed.sv
// Self-checking bench for div_fixed: scoreboard of expected results, popped on o_valid.
module tb_div_fixed;

  localparam int Lat = 58;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [31:0] i_a, i_b;
  logic [31:0] o_q;
  logic        o_valid, o_busy, o_dz, o_sat;

  typedef struct {
    logic [31:0] q;
    logic        dz;
    logic        sat;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   valid_cnt = 0;

  div_fixed u_dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_q     (o_q),
    .o_valid (o_valid),
    .o_busy  (o_busy),
    .o_dz    (o_dz),
    .o_sat   (o_sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   r;
    longint sa, sbv, qt;
    r.start_cyc = 0;
    r.dz        = 1'b0;
    r.sat       = 1'b0;
    r.q         = '0;
    if (b == 32'h0) begin
      r.dz = 1'b1;
      r.q  = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      qt  = (sa * 64'sd16777216) / sbv;
      if (qt > 64'sd2147483647) begin
        r.q   = 32'h7FFF_FFFF;
        r.sat = 1'b1;
      end else if (qt < -64'sd2147483648) begin
        r.q   = 32'h8000_0000;
        r.sat = 1'b1;
      end else begin
        r.q = qt[31:0];
      end
    end
    return r;
  endfunction

  // Monitor: every o_valid pops one expectation; latency counts edges from the sampling edge.
  always @(negedge clk) begin
    if (!rst && o_valid) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        check("spurious_valid", 64'(o_valid), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        check("q", 64'(o_q), 64'(mon_e.q));
        check("dz", 64'(o_dz), 64'(mon_e.dz));
        check("sat", 64'(o_sat), 64'(mon_e.sat));
        check("latency", 64'(cyc - mon_e.start_cyc), 64'(Lat));
        check("busy_at_valid", 64'(o_busy), 64'(0));
      end
    end
  end

  // Drive start in the current cycle (caller is just after a posedge).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input exp_t e);
    exp_t en;
    en           = e;
    i_a          = a;
    i_b          = b;
    i_start      = 1'b1;
    en.start_cyc = cyc;
    sb.push_back(en);
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_a     = $urandom;
    i_b     = $urandom;
  endtask

  task automatic start_div(input logic [31:0] a, input logic [31:0] b, input exp_t e);
    @(posedge clk);
    #1;
    issue(a, b, e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < Lat + 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      check("timeout", 64'(sb.size()), 64'(0));
      sb.delete();
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                     input logic dz, input logic sat);
    exp_t e;
    e.q         = q;
    e.dz        = dz;
    e.sat       = sat;
    e.start_cyc = 0;
    start_div(a, b, e);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("hold_q", 64'(o_q), 64'(q));
  endtask

  logic [31:0] va[10] = '{32'h0300_0000, 32'hFF00_0000, 32'h0100_0000, 32'hFF00_0000,
                          32'h6400_0000, 32'h8000_0000, 32'h8000_0000, 32'hFE00_0000,
                          32'h0000_0000, 32'h0000_0000};
  logic [31:0] vb[10] = '{32'h0200_0000, 32'h0400_0000, 32'h0300_0000, 32'h0300_0000,
                          32'h0080_0000, 32'hFF00_0000, 32'h0100_0000, 32'h0000_0000,
                          32'h0000_0000, 32'hFF00_0000};
  logic [31:0] vq[10] = '{32'h0180_0000, 32'hFFC0_0000, 32'h0055_5555, 32'hFFAA_AAAB,
                          32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                          32'h7FFF_FFFF, 32'h0000_0000};
  logic        vdz[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
  logic        vsat[10] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic [31:0] ra, rb;
    int          vc0;
    bit          seen;

    rst     = 1'b1;
    i_start = 1'b0;
    i_a     = '0;
    i_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_q", 64'(o_q), 64'(0));
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_dz", 64'(o_dz), 64'(0));
    check("rst_sat", 64'(o_sat), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run(va[i], vb[i], vq[i], vdz[i], vsat[i]);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : ($urandom & 32'h00FF_FFFF) | 32'h0000_0100;
      e  = model(ra, rb);
      run(ra, rb, e.q, e.dz, e.sat);
    end

    // Start pulsed while busy must be ignored.
    vc0 = valid_cnt;
    e   = model(32'h0300_0000, 32'h0200_0000);
    start_div(32'h0300_0000, 32'h0200_0000, e);
    check("busy_calc", 64'(o_busy), 64'(1));
    repeat (8) @(posedge clk);
    #1;
    i_start = 1'b1;
    i_a     = 32'h0100_0000;
    i_b     = 32'h0300_0000;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    wait_idle();
    repeat (Lat) @(posedge clk);
    check("one_valid", 64'(valid_cnt - vc0), 64'(1));

    // Back-to-back: re-issue in the o_valid cycle.
    e = model(32'h0700_0000, 32'hFE00_0000);
    start_div(32'h0700_0000, 32'hFE00_0000, e);
    seen = 1'b0;
    for (int i = 0; i < Lat + 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = o_valid;
    end
    if (!seen) begin
      check("b2b_first_valid", 64'(seen), 64'(1));
    end else begin
      e = model(32'hF900_0000, 32'h0050_0000);
      issue(32'hF900_0000, 32'h0050_0000, e);
    end
    wait_idle();

    // Reset mid-operation.
    e = model(32'hFF00_0000, 32'h0300_0000);
    start_div(32'hFF00_0000, 32'h0300_0000, e);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_q", 64'(o_q), 64'(0));
    check("abort_valid", 64'(o_valid), 64'(0));
    check("abort_busy", 64'(o_busy), 64'(0));
    check("abort_dz", 64'(o_dz), 64'(0));
    check("abort_sat", 64'(o_sat), 64'(0));
    sb.delete();
    vc0 = valid_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (Lat + 5) @(posedge clk);
    check("no_valid_after_abort", 64'(valid_cnt - vc0), 64'(0));
    run(32'h0100_0000, 32'h0300_0000, 32'h0055_5555, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_fixed.md
Name: div_fixed

Overview:
- Iterative signed fixed-point divider; the inverse of the fixed-point multiplier datapath in the training pipeline.
- Computes o_q = i_a / i_b on Q(WIDTH-FRAC).FRAC operands, with the same format out.
- Used for normalisation and learning-rate scaling, where a combinational divider is too large.
- Start/busy/valid handshake; restoring algorithm, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand and result width in bits (two's complement).
- FRAC, 24, number of fractional bits in operands and result.
- N (localparam), WIDTH+FRAC, number of iteration cycles; 56 at defaults.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- i_start  input  1  request; sampled only in IDLE.
- i_a  input  WIDTH  dividend, signed Q8.24; sampled with i_start.
- i_b  input  WIDTH  divisor, signed Q8.24; sampled with i_start.
- o_q  output  WIDTH  quotient, signed Q8.24; held until next result.
- o_valid  output  1  one-cycle pulse: o_q, o_dz and o_sat are new.
- o_busy  output  1  high in CALC and DONE.
- o_dz  output  1  divide-by-zero flag for the current result.
- o_sat  output  1  saturation flag for the current result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; o_q=0, o_valid=0, o_busy=0, o_dz=0, o_sat=0; internal registers cleared.
- Reset mid-operation aborts immediately. No o_valid is produced for the aborted request.
- FSM IDLE -> CALC: on a clk edge with i_start=1 in IDLE.
  - Latch sign = a[MSB]^b[MSB].
  - Latch |a| and |b| as (WIDTH+1)-bit magnitudes, so -2^(WIDTH-1) is exact.
  - Dividend = |a| << FRAC, width N+1. Clear remainder; iteration counter = N-1.
- CALC: each cycle performs one restoring step.
  - rem = {rem, next dividend MSB}; if rem >= |b| then rem -= |b| and shift 1 into the quotient, else shift 0.
  - Counter decrements. After N steps go to DONE.
- DONE, one cycle:
  - Negate the magnitude quotient if sign=1, so results truncate toward zero.
  - Saturate: positive magnitude > 2^(WIDTH-1)-1 gives 0x7FFFFFFF; negative magnitude > 2^(WIDTH-1) gives 0x80000000. Set o_sat in either case.
  - Register o_q, o_sat, o_dz; assert o_valid; return to IDLE.
- Latency: i_start sampled at edge t0 -> o_valid high in the cycle after edge t0+N+1. That is N+2 clocks, 58 at defaults. Latency is fixed and independent of data.
- o_busy: high from the edge after start through the DONE cycle inclusive. The next start is accepted in the cycle o_valid is high, because the FSM is already back in IDLE.
- i_start while o_busy=1 is ignored; no queuing. i_a and i_b may change freely after the start cycle.
- Divide by zero (i_b=0):
  - Full latency is still taken; the iteration runs, but its result is discarded.
  - o_q = 0x7FFFFFFF if i_a>=0, else 0x80000000. o_dz=1, o_sat=0.
- i_a=0 with a nonzero divisor gives o_q=0 exactly, including negative divisors (no -0 issue in two's complement).
- o_dz and o_sat update only with o_valid and hold otherwise.

Decomposition:
- Shared package dnn_fixed_pkg:
  - Q-format constants WIDTH and FRAC; saturation constants Q_MAX=0x7FFFFFFF and Q_MIN=0x80000000.
  - State encoding enum: IDLE, CALC, DONE.
- Sub-module div_fixed_step: a combinational single restoring step.
  - In: rem, dividend bit, divisor. Out: next rem, quotient bit.
  - Keeps the FSM/datapath file readable; reusable for a future unrolled or pipelined variant.

Test Plan:
- Basic and negative: a=0x03000000 (3.0), b=0x02000000 (2.0) -> o_q=0x01800000 (1.5) exactly 58 clocks after start, o_sat=0, o_dz=0. Then a=0xFF000000 (-1.0), b=0x04000000 (4.0) -> 0xFFC00000 (-0.25).
- Truncation: 1.0/3.0 -> 0x00555555; -1.0/3.0 -> 0xFFAAAAAB (toward zero).
- Saturation: 100.0/0.5 (0x64000000/0x00800000) -> 0x7FFFFFFF, o_sat=1. -128.0/-1.0 (0x80000000/0xFF000000) -> 0x7FFFFFFF, o_sat=1. -128.0/1.0 -> 0x80000000, o_sat=0.
- Divide by zero: a=0xFE000000, b=0 -> o_q=0x80000000, o_dz=1, o_valid after 58 clocks. a=0, b=0 -> 0x7FFFFFFF, o_dz=1.
- Handshake: pulse i_start at cycle 10 while busy -> ignored; exactly one o_valid. Re-issue start in the o_valid cycle -> accepted; second o_valid 58 clocks later.
- Reset mid-op: assert rst 20 clocks into CALC -> all outputs 0 asynchronously, no o_valid. After release, a new division completes correctly.
